// File: rtl/lc3_int_ctrl.sv
// lc3_int_ctrl: prioritised multi-source interrupt controller driving LC-3 INT.
// Define LC3_INT_EDGE_EN for edge-latched requests; level mode otherwise.
module lc3_int_ctrl #(
  parameter int         NUM_SRC  = 4,
  parameter int         PRIO_W   = 3,
  parameter logic [7:0] VEC_BASE = 8'h80,
  parameter int         SEL_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               cfgWE,
  input  logic [SEL_W-1:0]   cfgSel,
  input  logic               cfgEn,
  input  logic [PRIO_W-1:0]  cfgPrio,
  input  logic [PRIO_W-1:0]  curPrio,
  input  logic               intAck,
  output logic               INT,
  output logic [7:0]         intVector,
  output logic [PRIO_W-1:0]  intPrio,
  output logic [SEL_W-1:0]   intSrc,
  output logic               ackErr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_ACK
  } state_t;

  localparam logic [SEL_W:0] NUM_SRC_L = (SEL_W+1)'(NUM_SRC);

  state_t state_q, state_d;

  logic [NUM_SRC-1:0]             en_q, en_d;
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic [NUM_SRC-1:0]             irq_q;
  logic [NUM_SRC-1:0]             pend;
  logic [NUM_SRC-1:0]             act;

  logic               int_req_q, int_req_d;
  logic [7:0]         vec_q, vec_d;
  logic [PRIO_W-1:0]  int_prio_q, int_prio_d;
  logic [SEL_W-1:0]   int_src_q, int_src_d;
  logic               ack_err_q, ack_err_d;

  logic               win_found;
  logic [SEL_W-1:0]   win_src;
  logic [PRIO_W-1:0]  win_prio;
  logic               win_ok;
  logic               held_ok;

  always_comb begin
    en_d   = en_q;
    prio_d = prio_q;
    if (cfgWE && ({1'b0, cfgSel} < NUM_SRC_L)) begin
      en_d[cfgSel]   = cfgEn;
      prio_d[cfgSel] = cfgPrio;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= '0;
      prio_q <= '0;
      irq_q  <= '0;
    end else begin
      en_q   <= en_d;
      prio_q <= prio_d;
      irq_q  <= irq;
    end
  end

`ifdef LC3_INT_EDGE_EN
  logic [NUM_SRC-1:0] pend_q, pend_d;

  // A fresh edge in the retire cycle must survive the clear.
  always_comb begin
    pend_d = pend_q;
    if (state_q == S_ACK) begin
      pend_d[int_src_q] = 1'b0;
    end
    pend_d = pend_d | (irq & ~irq_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
`else
  assign pend = irq_q;
`endif

  assign act = pend & en_q;

  always_comb begin
    win_found = 1'b0;
    win_src   = '0;
    win_prio  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (act[i] && (!win_found || (prio_q[i] > win_prio))) begin
        win_found = 1'b1;
        win_src   = SEL_W'(i);
        win_prio  = prio_q[i];
      end
    end
  end

  assign win_ok  = win_found && (win_prio > curPrio);
  assign held_ok = act[int_src_q] && (prio_q[int_src_q] > curPrio);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    int_prio_d = int_prio_q;
    int_src_d  = int_src_q;
    ack_err_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ack_err_d = intAck;
        if (win_ok) begin
          state_d    = S_PEND;
          int_src_d  = win_src;
          vec_d      = VEC_BASE + 8'(win_src);
          int_prio_d = win_prio;
        end
      end
      S_PEND: begin
        if (intAck) begin
          state_d = S_ACK;
        end else if (!held_ok) begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        ack_err_d = intAck;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    int_req_d = (state_d == S_PEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      int_req_q  <= 1'b0;
      vec_q      <= VEC_BASE;
      int_prio_q <= '0;
      int_src_q  <= '0;
      ack_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_req_q  <= int_req_d;
      vec_q      <= vec_d;
      int_prio_q <= int_prio_d;
      int_src_q  <= int_src_d;
      ack_err_q  <= ack_err_d;
    end
  end

  assign INT       = int_req_q;
  assign intVector = vec_q;
  assign intPrio   = int_prio_q;
  assign intSrc    = int_src_q;
  assign ackErr    = ack_err_q;

endmodule

// File: tb/tb_lc3_int_ctrl.sv
// tb_lc3_int_ctrl: table vectors, handshake sequences and a randomized
// comparison against a behavioural model of lc3_int_ctrl.
module tb_lc3_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq;
  logic       cfgWE;
  logic [1:0] cfgSel;
  logic       cfgEn;
  logic [2:0] cfgPrio;
  logic [2:0] curPrio;
  logic       intAck;
  logic       INT;
  logic [7:0] intVector;
  logic [2:0] intPrio;
  logic [1:0] intSrc;
  logic       ackErr;

  int n_chk  = 0;
  int n_fail = 0;

  lc3_int_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .cfgWE     (cfgWE),
    .cfgSel    (cfgSel),
    .cfgEn     (cfgEn),
    .cfgPrio   (cfgPrio),
    .curPrio   (curPrio),
    .intAck    (intAck),
    .INT       (INT),
    .intVector (intVector),
    .intPrio   (intPrio),
    .intSrc    (intSrc),
    .ackErr    (ackErr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         pr[4];
    logic [3:0] en;
    logic [3:0] irq;
    logic [2:0] cur;
    logic       xint;
    logic [1:0] xsrc;
    logic [2:0] xprio;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(int p0, int p1, int p2, int p3,
                              logic [3:0] en, logic [3:0] rq, int cur,
                              int xi, int xs, int xp);
    vec_t v;
    v.pr[0] = p0;
    v.pr[1] = p1;
    v.pr[2] = p2;
    v.pr[3] = p3;
    v.en    = en;
    v.irq   = rq;
    v.cur   = 3'(cur);
    v.xint  = 1'(xi);
    v.xsrc  = 2'(xs);
    v.xprio = 3'(xp);
    return v;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    irq     = '0;
    cfgWE   = 1'b0;
    cfgSel  = '0;
    cfgEn   = 1'b0;
    cfgPrio = '0;
    curPrio = '0;
    intAck  = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cfg(int sel, logic en, int pr);
    cfgWE   = 1'b1;
    cfgSel  = 2'(sel);
    cfgEn   = en;
    cfgPrio = 3'(pr);
    tick();
    cfgWE = 1'b0;
  endtask

  // Behavioural model: request / blackout flags plus per-source arrays.
  bit       m_int, m_blk, m_err;
  int       m_src, m_prio;
  bit [7:0] m_vec;
  bit       m_en[4];
  int       m_pr[4];
  bit       m_irqq[4];
  bit       m_pend[4];
  bit       edge_mode;

  task automatic model_reset();
    m_int  = 0;
    m_blk  = 0;
    m_err  = 0;
    m_src  = 0;
    m_prio = 0;
    m_vec  = 8'h80;
    for (int i = 0; i < 4; i++) begin
      m_en[i]   = 0;
      m_pr[i]   = 0;
      m_irqq[i] = 0;
      m_pend[i] = 0;
    end
  endtask

  task automatic model_step();
    bit act[4];
    bit np[4];
    bit hold_ok;
    int w;
    int cur;
    cur = int'(curPrio);
    for (int i = 0; i < 4; i++) begin
      act[i] = (edge_mode ? m_pend[i] : m_irqq[i]) && m_en[i];
    end
    w = -1;
    for (int p = 7; p > cur && w < 0; p--) begin
      for (int i = 0; i < 4; i++) begin
        if (w < 0 && act[i] && m_pr[i] == p) w = i;
      end
    end
    hold_ok = act[m_src] && (m_pr[m_src] > cur);
    m_err = intAck && !m_int;
    for (int i = 0; i < 4; i++) begin
      np[i] = (m_pend[i] && !(m_blk && i == m_src)) ||
              (irq[i] && !m_irqq[i]);
    end
    if (m_int) begin
      if (intAck) begin
        m_int = 0;
        m_blk = 1;
      end else if (!hold_ok) begin
        m_int = 0;
      end
    end else if (m_blk) begin
      m_blk = 0;
    end else if (w >= 0) begin
      m_int  = 1;
      m_src  = w;
      m_vec  = 8'(8'h80 + w);
      m_prio = m_pr[w];
    end
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = np[i];
      m_irqq[i] = irq[i];
    end
    if (cfgWE) begin
      m_en[cfgSel] = cfgEn;
      m_pr[cfgSel] = int'(cfgPrio);
    end
  endtask

  initial begin
`ifdef LC3_INT_EDGE_EN
    edge_mode = 1;
`else
    edge_mode = 0;
`endif
    tbl[0]  = mk(5, 5, 7, 1, 4'hF, 4'hF, 2, 1, 2, 7);
    tbl[1]  = mk(5, 5, 7, 1, 4'hF, 4'hF, 7, 0, 0, 0);
    tbl[2]  = mk(5, 5, 7, 1, 4'hF, 4'b1011, 3, 1, 0, 5);
    tbl[3]  = mk(5, 5, 7, 1, 4'b0011, 4'hF, 4, 1, 0, 5);
    tbl[4]  = mk(5, 5, 7, 1, 4'hF, 4'b1000, 0, 1, 3, 1);
    tbl[5]  = mk(0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 0, 0);
    tbl[6]  = mk(2, 6, 6, 3, 4'hF, 4'b1110, 5, 1, 1, 6);
    tbl[7]  = mk(4, 4, 4, 4, 4'hF, 4'hF, 4, 0, 0, 0);
    tbl[8]  = mk(1, 1, 1, 7, 4'hF, 4'b1000, 6, 1, 3, 7);
    tbl[9]  = mk(1, 2, 3, 7, 4'b0111, 4'hF, 0, 1, 2, 3);
    tbl[10] = mk(3, 6, 2, 6, 4'hF, 4'b1010, 5, 1, 1, 6);

    do_reset();
    check("rst_int", 32'(INT), 32'd0);
    check("rst_vec", 32'(intVector), 32'h80);
    check("rst_prio", 32'(intPrio), 32'd0);
    check("rst_src", 32'(intSrc), 32'd0);
    check("rst_ackerr", 32'(ackErr), 32'd0);

    for (int t = 0; t < 11; t++) begin
      do_reset();
      for (int s = 0; s < 4; s++) cfg(s, tbl[t].en[s], tbl[t].pr[s]);
      curPrio = tbl[t].cur;
      irq     = tbl[t].irq;
      tick();
      tick();
      tick();
      check($sformatf("tbl%0d_int", t), 32'(INT), 32'(tbl[t].xint));
      check($sformatf("tbl%0d_src", t), 32'(intSrc), 32'(tbl[t].xsrc));
      check($sformatf("tbl%0d_prio", t), 32'(intPrio), 32'(tbl[t].xprio));
      check($sformatf("tbl%0d_vec", t), 32'(intVector),
            32'(8'h80) + 32'(tbl[t].xsrc));
    end

    // Single source: latency and acknowledge.
    do_reset();
    cfg(2, 1'b1, 4);
    irq = 4'b0100;
    tick();
    check("single_k_int", 32'(INT), 32'd0);
    tick();
    check("single_k1_int", 32'(INT), 32'd1);
    check("single_vec", 32'(intVector), 32'h82);
    check("single_prio", 32'(intPrio), 32'd4);
    check("single_src", 32'(intSrc), 32'd2);
    intAck = 1'b1;
    tick();
    check("ack_m_int", 32'(INT), 32'd0);
    check("ack_m_vec_hold", 32'(intVector), 32'h82);
    check("ack_m_ackerr", 32'(ackErr), 32'd0);
    intAck = 1'b0;
    irq    = 4'b0000;
    tick();
    tick();
    check("ack_m2_int", 32'(INT), 32'd0);
    intAck = 1'b1;
    tick();
    check("spur_idle_ackerr", 32'(ackErr), 32'd1);
    intAck = 1'b0;
    tick();
    check("spur_idle_clear", 32'(ackErr), 32'd0);

    // Strict compare, then retraction by disabling the winner.
    do_reset();
    cfg(1, 1'b1, 3);
    curPrio = 3'd3;
    irq     = 4'b0010;
    tick();
    tick();
    tick();
    check("strict_eq_int", 32'(INT), 32'd0);
    curPrio = 3'd2;
    tick();
    check("strict_gt_int", 32'(INT), 32'd1);
    check("strict_gt_src", 32'(intSrc), 32'd1);
    cfg(1, 1'b0, 3);
    check("retr_a_int", 32'(INT), 32'd1);
    tick();
    check("retr_a1_int", 32'(INT), 32'd0);
    intAck = 1'b1;
    tick();
    check("retr_ackerr", 32'(ackErr), 32'd1);
    intAck = 1'b0;
    tick();
    check("retr_ackerr_clr", 32'(ackErr), 32'd0);

    // New request edge during the ACK cycle re-asserts at m+2.
    do_reset();
    cfg(2, 1'b1, 4);
    irq = 4'b0100;
    tick();
    tick();
    check("edge_pend_int", 32'(INT), 32'd1);
    intAck = 1'b1;
    irq    = 4'b0000;
    tick();
    check("edge_m_int", 32'(INT), 32'd0);
    intAck = 1'b0;
    irq    = 4'b0100;
    tick();
    check("edge_m1_int", 32'(INT), 32'd0);
    tick();
    check("edge_m2_int", 32'(INT), 32'd1);
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
    tick();
    tick();
    check("held_m2_int", 32'(INT), edge_mode ? 32'd0 : 32'd1);

    // Asynchronous reset while requesting.
    do_reset();
    cfg(2, 1'b1, 4);
    irq = 4'b0100;
    tick();
    tick();
    check("rpend_int", 32'(INT), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rmid_int", 32'(INT), 32'd0);
    check("rmid_vec", 32'(intVector), 32'h80);
    check("rmid_src", 32'(intSrc), 32'd0);
    check("rmid_prio", 32'(intPrio), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("rmid_en_cleared", 32'(INT), 32'd0);

    // Randomized run against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq = 4'($urandom);
      if (m_int) intAck = ($urandom_range(0, 2) == 0);
      else intAck = ($urandom_range(0, 19) == 0);
      cfgWE   = ($urandom_range(0, 9) == 0);
      cfgSel  = 2'($urandom);
      cfgEn   = ($urandom_range(0, 3) != 0);
      cfgPrio = 3'($urandom);
      if ($urandom_range(0, 9) == 0) curPrio = 3'($urandom);
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("rand_c%0d", c),
            {17'd0, INT, intVector, intPrio, intSrc, ackErr},
            {17'd0, m_int, m_vec, 3'(m_prio), 2'(m_src), m_err});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_int_ctrl.md
# lc3_int_ctrl

Parametrised, multi-source prioritised interrupt controller feeding the LC-3 control FSM's `INT` input. It latches requests from `NUM_SRC` sources and arbitrates them by per-source priority against the current PSR priority. It holds a stable vector and priority for the control unit, and retires the request on the control unit's acknowledge. It replaces the single hard-wired interrupt line with configurable channels, priorities and vectors.

## Interface
- `NUM_SRC`, 4: number of interrupt sources, 1..16.
- `PRIO_W`, 3: priority width; matches PSR[10:8].
- `VEC_BASE`, 8'h80: vector of source 0; source i uses `VEC_BASE + i` (8-bit, wraps mod 256).
- `SEL_W`, `$clog2(NUM_SRC)` (min 1): derived index width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `irq` in NUM_SRC: raw source requests, synchronous to `clk`.
- `cfgWE` in 1: configuration write strobe.
- `cfgSel` in SEL_W: source being configured.
- `cfgEn` in 1: enable bit written.
- `cfgPrio` in PRIO_W: priority written.
- `curPrio` in PRIO_W: current PSR priority.
- `intAck` in 1: control unit accepts the interrupt (one-cycle pulse in INT0).
- `INT` out 1: interrupt request to the control unit.
- `intVector` out 8: vector of the held winner.
- `intPrio` out PRIO_W: priority of the held winner, for loading PSR[10:8].
- `intSrc` out SEL_W: index of the held winner.
- `ackErr` out 1: one-cycle pulse when `intAck` arrives outside PEND.

## Operation
- **Per-source state:** `en`, `prio` and `pend` registers, plus the sampled `irq_q`.
- **Configuration:** `cfgWE` writes `en`/`prio` of `cfgSel` at the clock edge. `cfgSel >= NUM_SRC` is ignored.
- **Pending:** a source is pending when `pend & en`.
- **Arbitration (combinational):** the winner is the pending source with the highest `prio`; on equal priority the lowest index wins.
  - The winner qualifies only if `prio > curPrio` (strict).
  - Priority 0 therefore never interrupts.
- **FSM states:** IDLE, PEND, ACK.
  - **IDLE:** if a qualifying winner exists, latch `intSrc`, `intVector` and `intPrio`, then go to PEND.
  - **PEND:** `INT`=1; the latched outputs are frozen.
    - `intAck`=1 goes to ACK. `intAck` always wins over retraction in the same cycle.
    - Otherwise, if the latched source is no longer pending, not enabled, or `prio <= curPrio`, retract to IDLE.
  - **ACK:** retire the request (see Configuration), then return to IDLE unconditionally. This gives a one-cycle blackout in which no new winner is latched.
- **Spurious acknowledge:** `intAck` in IDLE or ACK pulses `ackErr` and has no other effect.
- **Reset (asynchronous, any time including mid-handshake):**
  - State IDLE.
  - All `pend`, `en`, `prio` and `irq_q` cleared to 0.
  - `INT`=0, `intVector`=`VEC_BASE`, `intPrio`=0, `intSrc`=0, `ackErr`=0.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- **Request latency:** `irq` sampled high at edge k sets `pend` at edge k. The FSM enters PEND at edge k+1, so `INT` is high from k+1.
- **Acknowledge:** `intAck` sampled at edge m gives state ACK and `INT`=0 from m, and IDLE at m+1. The earliest next `INT` is at m+2.
- **Retraction:** `INT` falls one cycle after the disqualifying condition is sampled.
- **Outputs:** `intVector`/`intPrio`/`intSrc` change only on the IDLE→PEND transition and hold their values through PEND and ACK.
- **Configuration write:** visible to arbitration the cycle after `cfgWE`.

## Configuration
- **Macro `LC3_INT_EDGE_EN`:**
  - **Defined (edge mode):** `pend[i]` is set on a rising edge (`irq & ~irq_q`) and cleared in ACK for `intSrc`. A new edge on the same source in the ACK cycle wins, leaving it pending.
  - **Undefined (level mode):** `pend = irq_q`, and ACK clears nothing. The source must drop its request itself. Re-entry is prevented only by `curPrio` being raised to `intPrio`.

## Test plan
- **Single source:** NUM_SRC=4, source 2 `en`=1, `prio`=4, `curPrio`=0. Pulse `irq[2]` → `INT`=1 two edges later, `intVector`=8'h82, `intPrio`=4, `intSrc`=2. `intAck` → `INT`=0 the next cycle.
- **Arbitration and tie-break:** `prio` = {5,5,7,1}, all enabled, all `irq` together, `curPrio`=2 → `intSrc`=2. After ack with `curPrio`=7 → no `INT`. With `curPrio`=3 → `intSrc`=0 (tie-break with source 1).
- **Strict compare:** `prio`=3, `curPrio`=3 → `INT` stays 0. Set `curPrio`=2 → `INT` asserts one cycle later.
- **Retraction:** in PEND, clear `en` of the winner via `cfgWE` → `INT` falls within 2 cycles, and `ackErr` pulses if `intAck` then arrives.
- **Edge corner (LC3_INT_EDGE_EN):** a new `irq` edge on the winning source in the ACK cycle → the source stays pending, and `INT` re-asserts at m+2 if it still qualifies.
- **Reset mid-PEND:** assert `rst` while `INT`=1 → `INT`=0 and `intVector`=8'h80 immediately, with all `en` cleared.
